memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, sets how many consecutive data grants may pass while an instruction request waits; legal range 1..15.
REQ-002 CLK  input  1  Single clock; all state updates on its rising edge.
REQ-003 nRST  input  1  Reset, asynchronous, active-low.
REQ-004 iREN  input  1  Instruction fetch request; held by requester until iwait=0.
REQ-005 iaddr  input  32  Instruction word address.
REQ-006 dREN  input  1  Data read request; held until dwait=0.
REQ-007 dWEN  input  1  Data write request; held until dwait=0.
REQ-008 daddr  input  32  Data word address.
REQ-009 dstore  input  32  Data write value.
REQ-010 iwait  output  1  Low exactly in the cycle an instruction fetch completes.
REQ-011 dwait  output  1  Low exactly in the cycle a data access completes.
REQ-012 iload  output  32  Fetched instruction; valid when iwait=0.
REQ-013 dload  output  32  Loaded data; valid when dwait=0 after a read.
REQ-014 ramREN  output  1  RAM read strobe.
REQ-015 ramWEN  output  1  RAM write strobe.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data.
REQ-019 ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-020 FSM states: IDLE, IFETCH, DACCESS. All outputs are registered-state decodes plus combinational ramstate/ramload terms.
REQ-021 IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-022 IDLE -> DACCESS when (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX). Op, daddr, dstore latch at the transition edge.
REQ-023 IDLE -> IFETCH when iREN and the DACCESS condition is false. iaddr latches at the transition edge.
REQ-024 IDLE holds when no request is present.
REQ-025 IFETCH: ramREN=1, ramWEN=0, ramaddr=latched iaddr.
REQ-026 DACCESS drives ramaddr=latched daddr.
REQ-027 DACCESS write: ramWEN=1, ramREN=0, ramstore=latched dstore.
REQ-028 DACCESS read: ramREN=1, ramWEN=0.
REQ-029 dREN and dWEN both high: treat as a write.
REQ-030 Completion is the cycle with ramstate==ACCESS in the active state. The matching wait goes low that same cycle (combinational), iload/dload=ramload, and the next state is IDLE.
REQ-031 ramstate FREE, BUSY or ERROR in an active state: stay and keep driving the same strobes and address (ERROR is retried).
REQ-032 Minimum latency: request seen in IDLE at cycle 0, strobes asserted in cycle 1, earliest completion in cycle 1. There is always at least one IDLE cycle between consecutive grants.
REQ-033 If the granted requester deasserts its request before completion, go to IDLE next cycle with no wait pulse.
REQ-034 starve_cnt (4 bits):
- +1 on each data completion while iREN=1, saturating at STARVE_MAX;
- cleared on instruction completion;
- cleared in any cycle with iREN=0.
REQ-035 The non-granted requester's wait stays 1 throughout.
REQ-036 iload and dload output ramload unconditionally. Their value is defined only while the matching wait is 0.

Reset
REQ-037 nRST=0 immediately forces: state=IDLE, starve_cnt=0, latches=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, regardless of any access in flight.
REQ-038 An access interrupted by reset is dropped, not resumed. After release, arbitration restarts from IDLE on the next edge.

Verification
REQ-039 Lone fetch: iREN=1, iaddr=0x100, ramstate=ACCESS from the 2nd cycle, ramload=0xDEADBEEF. Required: ramREN=1, ramaddr=0x100 in cycle 1; iwait=0 and iload=0xDEADBEEF in that cycle; IDLE next.
REQ-040 Simultaneous iREN and dWEN (daddr=0x200, dstore=0x5A5A5A5A), starve_cnt=0. Required: data granted first (ramWEN=1, ramaddr=0x200, ramstore=0x5A5A5A5A); on its ACCESS, dwait=0 and iwait=1; then IDLE; then fetch.
REQ-041 Starvation, STARVE_MAX=4: iREN and dREN held continuously, RAM always ACCESS. Required: exactly 4 data completions, then an instruction grant, then starve_cnt=0.
REQ-042 Wait states: DACCESS read with ramstate BUSY,BUSY,ERROR,ACCESS. Required: ramREN and ramaddr stable for 4 cycles; dwait=0 only on the 4th.
REQ-043 Reset mid-access: nRST pulsed low while IFETCH with ramstate=BUSY. Required: ramREN=0 and iwait=1 asynchronously; after release with iREN still high, the fetch is re-granted from IDLE.
REQ-044 Abort: dREN dropped while DACCESS with ramstate=BUSY. Required: IDLE next cycle, no dwait=0 pulse, starve_cnt unchanged.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data access.
// Data has priority, and a starvation counter forces a fetch grant once the limit is reached.
module memory_arbiter #(
    parameter  int unsigned STARVE_MAX = 4,
    localparam int unsigned AW = 32,
    localparam int unsigned CW = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic          iwait,
    output logic          dwait,
    output logic [AW-1:0] iload,
    output logic [AW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  logic [1:0]    ramstate
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IFETCH  = 2'd1;
    localparam logic [1:0] DACCESS = 2'd2;

    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [1:0]    state, next_state;
    logic [CW-1:0] starve_cnt, next_cnt;
    logic [AW-1:0] lat_iaddr, lat_daddr, lat_dstore;
    logic          lat_wr;
    logic          dreq, starved, grant_d, grant_i, i_done, d_done;

    // Next-state, starvation counter and RAM-side decode
    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        dreq       = dREN | dWEN;
        starved    = iREN && (starve_cnt == STARVE_LIM);
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        i_done     = (state == IFETCH)  && iREN && (ramstate == RAM_ACCESS);
        d_done     = (state == DACCESS) && dreq && (ramstate == RAM_ACCESS);
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state)
            IDLE: begin
                grant_d = dreq && !starved;
                grant_i = iREN && !grant_d;
                if (grant_d)      next_state = DACCESS;
                else if (grant_i) next_state = IFETCH;
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = lat_iaddr;
                // A dropped request abandons the fetch without a completion pulse
                if (!iREN || i_done) next_state = IDLE;
            end
            DACCESS: begin
                ramREN   = !lat_wr;
                ramWEN   = lat_wr;
                ramaddr  = lat_daddr;
                ramstore = lat_wr ? lat_dstore : '0;
                if (!dreq || d_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (!iREN || i_done)                        next_cnt = '0;
        else if (d_done && starve_cnt != STARVE_LIM) next_cnt = starve_cnt + CW'(1);

        iwait = !i_done;
        dwait = !d_done;
        iload = ramload;
        dload = ramload;
    end

    // State, counter and request latches
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_iaddr  <= '0;
            lat_daddr  <= '0;
            lat_dstore <= '0;
            lat_wr     <= 1'b0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
            if (grant_i) lat_iaddr <= iaddr;
            if (grant_d) begin
                lat_daddr  <= daddr;
                lat_dstore <= dstore;
                lat_wr     <= dWEN;
            end
        end
    end

endmodule
